// File: rtl/id_stage_pkg.sv
// Shared opcode/funct constants, ALU control encodings and decoded-control bundle
// used by the fetch, decode and execute stages.
package id_stage_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSlt   = 6'b101010;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b100
    } alu_ctr_e;

    typedef struct packed {
        logic     jump;
        logic     branch;
        logic     ext_op;
        logic     reg_dst;
        logic     alu_src;
        logic     memto_reg;
        logic     reg_wr;
        logic     mem_wr;
        alu_ctr_e alu_ctr;
    } ctrl_t;

    // Instructions whose rt field is a source operand.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OpRtype) || (op == OpSw) || (op == OpBeq);
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: $0 hard-wired to zero, combinational reads with
// same-cycle write-to-read bypass.
module regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [4:0]  i_rd_addr_a,
    input  logic [4:0]  i_rd_addr_b,
    output logic [31:0] o_rd_data_a,
    output logic [31:0] o_rd_data_b
);

    logic [31:0] r_regs [32];
    logic        w_wr_ok;
    logic        w_byp_a;
    logic        w_byp_b;

    assign w_wr_ok = i_wr_en && (i_wr_addr != 5'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_byp_a     = w_wr_ok && (i_wr_addr == i_rd_addr_a);
    assign w_byp_b     = w_wr_ok && (i_wr_addr == i_rd_addr_b);
    assign o_rd_data_a = w_byp_a ? i_wr_data : r_regs[i_rd_addr_a];
    assign o_rd_data_b = w_byp_b ? i_wr_data : r_regs[i_rd_addr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID pipeline register, control decode, register
// file reads and single-cycle load-use hazard detection.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic [15:0] o_imm16,
    output logic [25:0] o_target,
    output logic        o_jump,
    output logic        o_branch,
    output logic        o_ext_op,
    output logic        o_reg_dst,
    output logic        o_alu_src,
    output logic        o_memto_reg,
    output logic        o_reg_wr,
    output logic        o_mem_wr,
    output logic [2:0]  o_alu_ctr,
    output logic [31:0] o_bus_a,
    output logic [31:0] o_bus_b,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [31:0] o_pc_id,
    output logic        o_valid,
    output logic        o_load_use
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_ld_valid;
    logic [4:0]  r_ld_rt;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_known;
    logic        w_decoded;
    logic        w_load_use;
    ctrl_t       w_ctrl;
    ctrl_t       w_out;

    assign w_op    = r_inst[31:26];
    assign w_funct = r_inst[5:0];
    assign w_rs    = r_inst[25:21];
    assign w_rt    = r_inst[20:16];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst  <= NOP_INST;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= NOP_INST;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!(i_stall || w_load_use)) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    // Clearing ld_valid on the hazard edge limits LoadUse to one bubble per load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld_valid <= 1'b0;
            r_ld_rt    <= '0;
        end else if (i_flush || w_load_use) begin
            r_ld_valid <= 1'b0;
        end else if (!i_stall) begin
            r_ld_valid <= w_decoded && (w_op == OpLw);
            r_ld_rt    <= w_rt;
        end
    end

    always_comb begin
        w_ctrl  = '0;
        w_known = 1'b1;
        case (w_op)
            OpRtype: begin
                w_ctrl.reg_dst = 1'b1;
                w_ctrl.reg_wr  = 1'b1;
                case (w_funct)
                    FnAddu:  w_ctrl.alu_ctr = AluAdd;
                    FnSubu:  w_ctrl.alu_ctr = AluSub;
                    FnAnd:   w_ctrl.alu_ctr = AluAnd;
                    FnOr:    w_ctrl.alu_ctr = AluOr;
                    FnSlt:   w_ctrl.alu_ctr = AluSlt;
                    default: w_known = 1'b0;
                endcase
            end
            OpOri: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_ctr = AluOr;
            end
            OpAddiu: begin
                w_ctrl.ext_op  = 1'b1;
                w_ctrl.alu_src = 1'b1;
                w_ctrl.reg_wr  = 1'b1;
            end
            OpLw: begin
                w_ctrl.ext_op    = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.memto_reg = 1'b1;
                w_ctrl.reg_wr    = 1'b1;
            end
            OpSw: begin
                w_ctrl.ext_op  = 1'b1;
                w_ctrl.alu_src = 1'b1;
                w_ctrl.mem_wr  = 1'b1;
            end
            OpBeq: begin
                w_ctrl.branch  = 1'b1;
                w_ctrl.alu_ctr = AluSub;
            end
            OpJ: begin
                w_ctrl.jump = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_decoded  = r_valid && w_known;
    assign w_load_use = r_ld_valid && (r_ld_rt != 5'd0) && w_decoded &&
                        ((w_rs == r_ld_rt) || (reads_rt(w_op) && (w_rt == r_ld_rt)));
    assign w_out      = (w_decoded && !w_load_use) ? w_ctrl : ctrl_t'('0);

    assign o_jump      = w_out.jump;
    assign o_branch    = w_out.branch;
    assign o_ext_op    = w_out.ext_op;
    assign o_reg_dst   = w_out.reg_dst;
    assign o_alu_src   = w_out.alu_src;
    assign o_memto_reg = w_out.memto_reg;
    assign o_reg_wr    = w_out.reg_wr;
    assign o_mem_wr    = w_out.mem_wr;
    assign o_alu_ctr   = w_out.alu_ctr;

    assign o_imm16    = r_inst[15:0];
    assign o_target   = r_inst[25:0];
    assign o_rs       = w_rs;
    assign o_rt       = w_rt;
    assign o_rd       = r_inst[15:11];
    assign o_pc_id    = r_pc;
    assign o_valid    = r_valid;
    assign o_load_use = w_load_use;

    regfile u_regfile (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_rd_addr_a (w_rs),
        .i_rd_addr_b (w_rt),
        .o_rd_data_a (o_bus_a),
        .o_rd_data_b (o_bus_b)
    );

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, instruction word loaded into the IF/ID register on reset or flush.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Inst  input  32  fetched instruction from the fetch stage.
REQ-005 PC  input  32  address of Inst.
REQ-006 Stall  input  1  hold the IF/ID register contents.
REQ-007 Flush  input  1  replace the IF/ID contents with a bubble.
REQ-008 WrEn  input  1  register-file write enable from writeback.
REQ-009 WrAddr  input  5  register-file write index.
REQ-010 WrData  input  32  register-file write data.
REQ-011 imm16  output  16  Inst[15:0] of the held instruction.
REQ-012 target  output  26  Inst[25:0] of the held instruction.
REQ-013 Jump, Branch, ExtOp, RegDst, ALUSrc, MemtoReg, RegWr, MemWr  output  1 each  decoded control.
REQ-014 ALUctr  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-015 busA, busB  output  32  register reads of rs, rt.
REQ-016 Rs, Rt, Rd  output  5 each  register fields; PC_ID  output  32  held PC; Valid  output  1  held instruction is real.
REQ-017 LoadUse  output  1  load-use hazard request to the fetch stage.

Function
REQ-018 IF/ID register SHALL update on each rising CLK edge: Flush=1 loads NOP_INST, PC_ID=0, Valid=0; else Stall=1 holds; else captures Inst, PC, Valid=1.
REQ-019 Flush SHALL take priority over Stall when both are asserted.
REQ-020 Decode SHALL be combinational from the held instruction, zero added latency; instruction at Inst appears on outputs one cycle after capture.
REQ-021 Decoding SHALL cover: R-type (op 000000) funct 100001 addu, 100011 subu, 100100 and, 100101 or, 101010 slt; ori 001101; addiu 001001; lw 100011; sw 101011; beq 000100; j 000010.
REQ-022 R-type: RegDst=1, RegWr=1, ALUSrc=0; ori: ExtOp=0, ALUSrc=1, RegWr=1, ALUctr=011; addiu: ExtOp=1, ALUSrc=1, RegWr=1, ALUctr=000.
REQ-023 lw: ExtOp=1, ALUSrc=1, MemtoReg=1, RegWr=1, ALUctr=000; sw: ExtOp=1, ALUSrc=1, MemWr=1, ALUctr=000; beq: Branch=1, ALUctr=001; j: Jump=1.
REQ-024 Unlisted opcodes/functs, Valid=0, or LoadUse=1 SHALL force all control outputs to 0 (bubble); imm16/target/Rs/Rt/Rd still reflect the held word.
REQ-025 Register file: 32x32; register 0 reads 0 and ignores writes; write on rising edge when WrEn=1 and WrAddr!=0.
REQ-026 Reads combinational; same-cycle write to the read index (nonzero) SHALL be bypassed so busA/busB show WrData.
REQ-027 Load tracker: when the stage advances (Stall=0, Flush=0) it SHALL record ld_valid = (held instruction is a valid lw) and ld_rt = its Rt; held otherwise; Flush clears ld_valid.
REQ-028 LoadUse=1 when ld_valid=1, ld_rt!=0, and held instruction reads ld_rt (Rs for all decoded types; Rt for R-type, sw, beq).
REQ-029 While LoadUse=1 the stage SHALL internally hold the IF/ID register as if Stall=1 and clear ld_valid on that edge, so LoadUse lasts exactly one cycle per hazard.

Reset
REQ-030 Reset=1 SHALL asynchronously set IF/ID to NOP_INST, PC_ID=0, Valid=0, ld_valid=0, ld_rt=0, all 32 registers to 0; all control outputs, LoadUse, busA, busB read 0.
REQ-031 Reset asserted mid-stall or mid-hazard SHALL abandon it; first edge after release captures Inst normally.

Structure
REQ-032 Opcode/funct constants and ALUctr encodings SHALL live in a shared package used also by the ALU and fetch stage.
REQ-033 The register file SHALL be one sub-module, regfile, with bypass inside it; decode and IF/ID register remain in id_stage.

Verification
REQ-034 Reset, then Inst=32'h3421_00FF (ori $1,$1,0xFF), PC=0x4 -> next cycle ALUSrc=1, RegWr=1, ExtOp=0, ALUctr=011, imm16=0x00FF, PC_ID=0x4, Valid=1.
REQ-035 WrEn=1, WrAddr=5, WrData=0xDEADBEEF with held instruction reading rs=5 -> busA=0xDEADBEEF same cycle; WrAddr=0 -> busA stays 0 for rs=0.
REQ-036 lw $2,0($1) followed by addu $3,$2,$4 -> LoadUse=1 for one cycle, controls zero, addu held, then addu decodes with RegWr=1, LoadUse=0.
REQ-037 Stall=1 and Flush=1 together with Inst=0x0800_0010 -> Valid=0, Jump=0; Stall alone -> outputs unchanged for every stalled cycle.
REQ-038 j 0x0000010 (Inst=0x0800_0010) -> Jump=1, target=26'h10; undefined op 6'b111111 -> all controls 0, Valid=1.
